// File: rtl/shifter_operand_pipe_if.sv
// Handshake and operand bus for shifter_operand_pipe.
// SHIFTER_FLAGS_EN adds the registered neg_out/zero_out flag signals.
interface shifter_operand_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic             imm_mode;
  logic [7:0]       imm8;
  logic [3:0]       rot4;
  logic             sh_by_reg;
  logic [1:0]       sh_type;
  logic [7:0]       sh_amt;
  logic             carry_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic [TAG_W-1:0] tag_out;
`ifdef SHIFTER_FLAGS_EN
  logic             neg_out;
  logic             zero_out;
`endif

  modport master (
    output in_valid, op_a, imm_mode, imm8, rot4, sh_by_reg, sh_type, sh_amt,
    output carry_in, tag_in, out_ready,
    input  in_ready, out_valid, result, carry_out, tag_out
`ifdef SHIFTER_FLAGS_EN
    , input neg_out, zero_out
`endif
  );

  modport slave (
    input  in_valid, op_a, imm_mode, imm8, rot4, sh_by_reg, sh_type, sh_amt,
    input  carry_in, tag_in, out_ready,
    output in_ready, out_valid, result, carry_out, tag_out
`ifdef SHIFTER_FLAGS_EN
    , output neg_out, zero_out
`endif
  );
endinterface

// File: rtl/shifter_operand_pipe.sv
// Two-stage pipelined data-processing shifter operand with carry-out, handshake and flush.
// Optional SHIFTER_FLAGS_EN registers neg_out/zero_out alongside the result.
module shifter_operand_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  shifter_operand_pipe_if.slave bus
);
  localparam int unsigned AMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_e;

  function automatic logic [WIDTH-1:0] shl_f(input logic [WIDTH-1:0] x, input logic [AMT_W-1:0] s);
    logic [WIDTH-1:0] y;
    y = x;
    for (int unsigned k = 0; k < AMT_W; k++)
      if (s[k]) y = y << (1 << k);
    return y;
  endfunction

  // One right-going barrel: rot=1 rotates, otherwise vacated bits take fill.
  function automatic logic [WIDTH-1:0] shr_f(input logic [WIDTH-1:0] x, input logic [AMT_W-1:0] s,
                                             input logic rot, input logic fill);
    logic [WIDTH-1:0] y;
    y = x;
    for (int unsigned k = 0; k < AMT_W; k++)
      if (s[k]) begin
        if (rot) y = (y >> (1 << k)) | (y << (WIDTH - (1 << k)));
        else     y = (y >> (1 << k)) | ({WIDTH{fill}} << (WIDTH - (1 << k)));
      end
    return y;
  endfunction

  logic             s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0] a_q;
  logic             imm_mode_q, by_reg_q, cin_q;
  logic [7:0]       imm8_q, amt_q;
  logic [3:0]       rot4_q;
  sh_type_e         type_q;
  logic [TAG_W-1:0] tag1_q, tag2_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;

  logic s2_can_load, s1_adv, accept;

  assign s2_can_load  = !s2_valid_q || bus.out_ready;
  assign s1_adv       = s1_valid_q && s2_can_load;
  assign bus.in_ready = !flush && (!s1_valid_q || s2_can_load);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      imm_mode_q <= 1'b0;
      imm8_q     <= '0;
      rot4_q     <= '0;
      by_reg_q   <= 1'b0;
      type_q     <= SH_LSL;
      amt_q      <= '0;
      cin_q      <= 1'b0;
      tag1_q     <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      a_q        <= bus.op_a;
      imm_mode_q <= bus.imm_mode;
      imm8_q     <= bus.imm8;
      rot4_q     <= bus.rot4;
      by_reg_q   <= bus.sh_by_reg;
      type_q     <= sh_type_e'(bus.sh_type);
      amt_q      <= bus.sh_amt;
      cin_q      <= bus.carry_in;
      tag1_q     <= bus.tag_in;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  logic [AMT_W-1:0] n, n_m1, n_neg, rot_n;
  logic             n_zero, m_zero, m_eq, m_gt, sign, fill;
  logic [WIDTH-1:0] rot_src, rot_res, shr_res, shl_res;

  always_comb begin
    n       = amt_q[AMT_W-1:0];
    n_m1    = n - AMT_W'(1);
    n_neg   = '0 - n;
    n_zero  = (n == '0);
    m_zero  = (amt_q == '0);
    m_eq    = (amt_q == 8'(WIDTH));
    m_gt    = (amt_q > 8'(WIDTH));
    sign    = a_q[WIDTH-1];
    fill    = (type_q == SH_ASR) && sign;
    // The rotator is shared between the immediate form and register ROR.
    rot_src = imm_mode_q ? WIDTH'(imm8_q) : a_q;
    rot_n   = imm_mode_q ? AMT_W'({rot4_q, 1'b0}) : n;
    rot_res = shr_f(rot_src, rot_n, 1'b1, 1'b0);
    shr_res = shr_f(a_q, n, 1'b0, fill);
    shl_res = shl_f(a_q, n);
  end

  always_comb begin
    result_d = a_q;
    carry_d  = cin_q;
    if (imm_mode_q) begin
      result_d = rot_res;
      carry_d  = (rot4_q == '0) ? cin_q : rot_res[WIDTH-1];
    end else if (!by_reg_q) begin
      unique case (type_q)
        SH_LSL: if (!n_zero) begin result_d = shl_res; carry_d = a_q[n_neg]; end
        SH_LSR: if (n_zero) begin result_d = '0; carry_d = sign; end
                else begin result_d = shr_res; carry_d = a_q[n_m1]; end
        SH_ASR: if (n_zero) begin result_d = {WIDTH{sign}}; carry_d = sign; end
                else begin result_d = shr_res; carry_d = a_q[n_m1]; end
        SH_ROR: if (n_zero) begin result_d = {cin_q, a_q[WIDTH-1:1]}; carry_d = a_q[0]; end
                else begin result_d = rot_res; carry_d = a_q[n_m1]; end
      endcase
    end else if (!m_zero) begin
      // Amounts below WIDTH fit in n, so n stands in for m there.
      unique case (type_q)
        SH_LSL: if (m_gt) begin result_d = '0; carry_d = 1'b0; end
                else if (m_eq) begin result_d = '0; carry_d = a_q[0]; end
                else begin result_d = shl_res; carry_d = a_q[n_neg]; end
        SH_LSR: if (m_gt) begin result_d = '0; carry_d = 1'b0; end
                else if (m_eq) begin result_d = '0; carry_d = sign; end
                else begin result_d = shr_res; carry_d = a_q[n_m1]; end
        SH_ASR: if (m_gt || m_eq) begin result_d = {WIDTH{sign}}; carry_d = sign; end
                else begin result_d = shr_res; carry_d = a_q[n_m1]; end
        SH_ROR: if (n_zero) begin result_d = a_q; carry_d = sign; end
                else begin result_d = rot_res; carry_d = a_q[n_m1]; end
      endcase
    end
  end

`ifdef SHIFTER_FLAGS_EN
  logic neg_q, zero_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      tag2_q     <= '0;
`ifdef SHIFTER_FLAGS_EN
      neg_q      <= 1'b0;
      zero_q     <= 1'b0;
`endif
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_can_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        tag2_q   <= tag1_q;
`ifdef SHIFTER_FLAGS_EN
        neg_q    <= result_d[WIDTH-1];
        zero_q   <= (result_d == '0);
`endif
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.tag_out   = tag2_q;
`ifdef SHIFTER_FLAGS_EN
  assign bus.neg_out   = neg_q;
  assign bus.zero_out  = zero_q;
`endif
endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Scoreboard bench for shifter_operand_pipe (WIDTH=32): directed vectors, stall, flush, async reset.
module tb_shifter_operand_pipe;
  localparam int unsigned W  = 32;
  localparam int unsigned TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  shifter_operand_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus();
  shifter_operand_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic        im;
    logic [7:0]  i8;
    logic [3:0]  r4;
    logic        br;
    logic [1:0]  ty;
    logic [7:0]  amt;
    logic [31:0] a;
    logic        cin;
    logic [31:0] er;
    logic        ec;
  } vec_t;

  exp_t sb[$];
  vec_t vq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic im, input logic [7:0] i8, input logic [3:0] r4, input logic br,
                      input logic [1:0] ty, input logic [7:0] amt, input logic [31:0] a,
                      input logic cin, input logic [31:0] er, input logic ec);
    vec_t v;
    v.im = im; v.i8 = i8; v.r4 = r4; v.br = br; v.ty = ty; v.amt = amt;
    v.a = a; v.cin = cin; v.er = er; v.ec = ec;
    vq.push_back(v);
  endtask

  task automatic set_vec(input int unsigned idx, input logic [3:0] tag);
    bus.imm_mode  = vq[idx].im;
    bus.imm8      = vq[idx].i8;
    bus.rot4      = vq[idx].r4;
    bus.sh_by_reg = vq[idx].br;
    bus.sh_type   = vq[idx].ty;
    bus.sh_amt    = vq[idx].amt;
    bus.op_a      = vq[idx].a;
    bus.carry_in  = vq[idx].cin;
    bus.tag_in    = tag;
    bus.in_valid  = 1'b1;
  endtask

  task automatic wait_accept(input int unsigned idx, input logic [3:0] tag);
    int unsigned cyc;
    logic rdy;
    exp_t e;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 50) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("accept_timeout", 32'(rdy), 32'd1);
    if (rdy) begin
      e.r = vq[idx].er; e.c = vq[idx].ec; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic issue_vec(input int unsigned idx, input logic [3:0] tag);
    set_vec(idx, tag);
    wait_accept(idx, tag);
  endtask

  task automatic drain();
    int unsigned cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got tag %0h result 0x%0h, required no output",
                 bus.tag_out, bus.result);
      end else begin
        chk("out_result", bus.result, sb[0].r);
        chk("out_carry", 32'(bus.carry_out), 32'(sb[0].c));
        chk("out_tag", 32'(bus.tag_out), 32'(sb[0].tag));
`ifdef SHIFTER_FLAGS_EN
        chk("out_neg", 32'(bus.neg_out), 32'(sb[0].r[31]));
        chk("out_zero", 32'(bus.zero_out), 32'(sb[0].r == 32'd0));
`endif
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.op_a = '0; bus.imm_mode = 1'b0; bus.imm8 = '0; bus.rot4 = '0;
    bus.sh_by_reg = 1'b0; bus.sh_type = '0; bus.sh_amt = '0; bus.carry_in = 1'b0;
    bus.tag_in = '0; bus.out_ready = 1'b1;

    //   im  imm8   r4 br ty     amt    a             cin  result        c
    addv(1, 8'hFF, 4'd4,  0, 2'd0, 8'd0,  32'h0,        0, 32'hFF000000, 1); // 0
    addv(1, 8'hFF, 4'd0,  0, 2'd0, 8'd0,  32'h0,        0, 32'h000000FF, 0); // 1
    addv(1, 8'h12, 4'd0,  0, 2'd0, 8'd0,  32'h0,        1, 32'h00000012, 1); // 2
    addv(1, 8'h3F, 4'd1,  0, 2'd0, 8'd0,  32'h0,        0, 32'hC000000F, 1); // 3
    addv(1, 8'h01, 4'd15, 1, 2'd2, 8'd0,  32'h80000000, 1, 32'h00000004, 0); // 4
    addv(0, 8'h0,  4'd0,  0, 2'd1, 8'd0,  32'h80000001, 0, 32'h00000000, 1); // 5
    addv(0, 8'h0,  4'd0,  0, 2'd0, 8'd4,  32'hF000000F, 0, 32'h000000F0, 1); // 6
    addv(0, 8'h0,  4'd0,  0, 2'd3, 8'd0,  32'h00000003, 1, 32'h80000001, 1); // 7
    addv(0, 8'h0,  4'd0,  0, 2'd0, 8'd0,  32'h00001234, 0, 32'h00001234, 0); // 8
    addv(0, 8'h0,  4'd0,  0, 2'd2, 8'd0,  32'h80000000, 0, 32'hFFFFFFFF, 1); // 9
    addv(0, 8'h0,  4'd0,  0, 2'd2, 8'd4,  32'h80000010, 0, 32'hF8000001, 0); // 10
    addv(0, 8'h0,  4'd0,  0, 2'd3, 8'd8,  32'h12345678, 0, 32'h78123456, 0); // 11
    addv(0, 8'h0,  4'd0,  0, 2'd1, 8'd1,  32'h00000003, 0, 32'h00000001, 1); // 12
    addv(0, 8'h0,  4'd0,  0, 2'd0, 8'h24, 32'h00000001, 0, 32'h00000010, 0); // 13
    addv(0, 8'h0,  4'd0,  1, 2'd0, 8'd32, 32'h00000001, 0, 32'h00000000, 1); // 14
    addv(0, 8'h0,  4'd0,  1, 2'd0, 8'd33, 32'h00000001, 0, 32'h00000000, 0); // 15
    addv(0, 8'h0,  4'd0,  1, 2'd0, 8'd0,  32'h00000001, 1, 32'h00000001, 1); // 16
    addv(0, 8'h0,  4'd0,  1, 2'd2, 8'd40, 32'h80000000, 0, 32'hFFFFFFFF, 1); // 17
    addv(0, 8'h0,  4'd0,  1, 2'd1, 8'd32, 32'h80000000, 0, 32'h00000000, 1); // 18
    addv(0, 8'h0,  4'd0,  1, 2'd1, 8'd33, 32'hFFFFFFFF, 0, 32'h00000000, 0); // 19
    addv(0, 8'h0,  4'd0,  1, 2'd3, 8'd32, 32'h80000001, 0, 32'h80000001, 1); // 20
    addv(0, 8'h0,  4'd0,  1, 2'd3, 8'd36, 32'h0000001F, 0, 32'hF0000001, 1); // 21
    addv(0, 8'h0,  4'd0,  1, 2'd0, 8'd31, 32'h00000003, 0, 32'h80000000, 1); // 22
    addv(0, 8'h0,  4'd0,  1, 2'd2, 8'd31, 32'h7FFFFFFF, 0, 32'h00000000, 1); // 23
    addv(0, 8'h0,  4'd0,  1, 2'd3, 8'd0,  32'h00000005, 0, 32'h00000005, 0); // 24
    addv(0, 8'h0,  4'd0,  1, 2'd1, 8'd4,  32'h000000F0, 0, 32'h0000000F, 0); // 25
    addv(0, 8'h0,  4'd0,  1, 2'd2, 8'd32, 32'h7FFFFFFF, 0, 32'h00000000, 0); // 26

    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_carry", 32'(bus.carry_out), 32'd0);
    chk("rst_tag", 32'(bus.tag_out), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int unsigned i = 0; i < vq.size(); i++) issue_vec(i, 4'(i));
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: two accepts fill the pipe, third waits.
    bus.out_ready = 1'b0;
    issue_vec(0, 4'd1);
    issue_vec(10, 4'd2);
    set_vec(7, 4'd3);
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_accept(7, 4'd3);
    bus.in_valid = 1'b0;
    drain();

    // Flush with both stages valid and a pending input.
    bus.out_ready = 1'b0;
    issue_vec(1, 4'd5);
    issue_vec(2, 4'd6);
    set_vec(3, 4'd7);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("flush_recover_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    issue_vec(3, 4'd8);
    bus.in_valid = 1'b0;
    drain();

    // Asynchronous reset mid-stream while a result is held.
    bus.out_ready = 1'b0;
    issue_vec(6, 4'd9);
    issue_vec(10, 4'd10);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    chk("arst_carry", 32'(bus.carry_out), 32'd0);
    chk("arst_tag", 32'(bus.tag_out), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    issue_vec(11, 4'd11);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_two_cycles", 32'(bus.out_valid), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
